// File: rtl/add_cmp_pkg.sv
// Shared types and defaults for the add-compare-select decision pipeline.
package add_cmp_pkg;

  typedef enum logic {
    ST_LO = 1'b0,
    ST_HI = 1'b1
  } dec_state_t;

  localparam int unsigned HI_CODE_DEF = 5;
  localparam int unsigned LO_CODE_DEF = 2;
  localparam int unsigned THRESH_DEF  = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < value; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/add_cmp_persist.sv
// Hysteresis filter: the decision state flips only after PERSIST
// consecutive samples disagree with it.
module add_cmp_persist
  import add_cmp_pkg::*;
#(
  parameter int unsigned PERSIST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       above,
  output dec_state_t state
);

  localparam int unsigned       CNT_W    = clog2(PERSIST + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERSIST - 1);

  logic [CNT_W-1:0] cnt;
  logic             disagree;

  assign disagree = above ^ (state == ST_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LO;
      cnt   <= '0;
    end else if (en) begin
      if (!disagree) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        state <= (state == ST_HI) ? ST_LO : ST_HI;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/add_cmp_pipe.sv
// Two-stage add/compare decision pipeline with valid/ready handshake,
// selectable wrap/full-width sum and persistence-filtered output code.
module add_cmp_pipe
  import add_cmp_pkg::*;
#(
  parameter int unsigned      WIDTH   = 3,
  parameter int unsigned      OUT_W   = 3,
  parameter logic [WIDTH:0]   THRESH  = (WIDTH + 1)'(THRESH_DEF),
  parameter logic [OUT_W-1:0] HI_CODE = OUT_W'(HI_CODE_DEF),
  parameter logic [OUT_W-1:0] LO_CODE = OUT_W'(LO_CODE_DEF),
  parameter logic             WRAP    = 1'b1,
  parameter int unsigned      PERSIST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_late,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_code,
  output logic             out_above,
  output logic [WIDTH:0]   out_sum
);

  logic             s1_valid;
  logic [WIDTH:0]   s1_sum;
  logic [WIDTH:0]   full_sum;
  logic [WIDTH:0]   sum_c;
  logic             adv2;
  logic             in_xfer;
  logic             move;
  dec_state_t       state;

  assign full_sum = {1'b0, a_late} + {1'b0, b};
  assign sum_c    = WRAP ? {1'b0, full_sum[WIDTH-1:0]} : full_sum;

  assign adv2     = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || adv2);
  assign in_xfer  = in_valid && in_ready;
  assign move     = s1_valid && adv2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_sum   <= sum_c;
    end else if (move) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_above <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sum   <= s1_sum;
        out_above <= (s1_sum >= THRESH);
      end
    end
  end

  add_cmp_persist #(
    .PERSIST(PERSIST)
  ) u_persist (
    .clk  (clk),
    .rst  (rst),
    .en   (move),
    .above(s1_sum >= THRESH),
    .state(state)
  );

  // The filter state register updates on the same edge as stage 2, so
  // decoding it directly yields the code after that sample's update.
  assign out_code = (state == ST_HI) ? HI_CODE : LO_CODE;

endmodule

// File: tb/tb_add_cmp_pipe.sv
// Bench for add_cmp_pipe: three configurations share one stimulus stream
// and are checked by directed scenarios plus a queue-based scoreboard.
module tb_add_cmp_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] a_late = '0;
  logic [2:0] b = '0;

  logic       in_ready  [3];
  logic       out_valid [3];
  logic       out_above [3];
  logic [3:0] out_sum   [3];
  logic [2:0] out_code  [3];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0][3:0] sum;
    logic [2:0]      above;
    logic [2:0][2:0] code;
  } exp_t;

  exp_t q[$];
  bit   m_hi;
  int   run;

  always #5 clk = ~clk;

  add_cmp_pipe u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a_late(a_late), .b(b), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_code(out_code[0]), .out_above(out_above[0]), .out_sum(out_sum[0])
  );

  add_cmp_pipe #(.WRAP(1'b0)) u_full (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a_late(a_late), .b(b), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_code(out_code[1]), .out_above(out_above[1]), .out_sum(out_sum[1])
  );

  add_cmp_pipe #(.PERSIST(3)) u_p3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .a_late(a_late), .b(b), .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_code(out_code[2]), .out_above(out_above[2]), .out_sum(out_sum[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard: instance 0 wraps/PERSIST=1, 1 is full width, 2 has PERSIST=3.
  task automatic monitor();
    exp_t e;
    int   s;
    bit   ab, exp_rdy;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete(); m_hi = 1'b0; run = 0;
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (in_ready[i] !== 1'b0) begin
            errors++; $display("FAIL mon_rst_ready[%0d]: got %b want 0", i, in_ready[i]);
          end
        end
      end else begin
        exp_rdy = !(q.size() == 2 && !out_ready);
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (in_ready[i] !== exp_rdy) begin
            errors++; $display("FAIL mon_in_ready[%0d]: got %b want %b", i, in_ready[i], exp_rdy);
          end
          if (q.size() == 0 || q.size() == 2) begin
            checks++;
            if (out_valid[i] !== (q.size() == 2)) begin
              errors++; $display("FAIL mon_out_valid[%0d]: got %b want %b (in flight %0d)",
                                 i, out_valid[i], q.size() == 2, q.size());
            end
          end
        end
        if (out_valid[0] && out_ready && q.size() > 0) begin
          e = q.pop_front();
          for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_sum[i] !== e.sum[i] || out_above[i] !== e.above[i] || out_code[i] !== e.code[i]) begin
              errors++;
              $display("FAIL mon_data[%0d]: got sum=%0d above=%b code=%0d want sum=%0d above=%b code=%0d",
                       i, out_sum[i], out_above[i], out_code[i], e.sum[i], e.above[i], e.code[i]);
            end
          end
        end
        if (in_valid && in_ready[0]) begin
          for (int i = 0; i < 3; i++) begin
            s = int'(a_late) + int'(b);
            if (i != 1) s = s % 8;
            ab = (s >= 4);
            e.sum[i]   = 4'(s);
            e.above[i] = ab;
            if (i < 2) begin
              e.code[i] = ab ? 3'd5 : 3'd2;
            end else begin
              // run = length of the current streak of samples opposing the decision
              if (ab != m_hi) begin
                run++;
                if (run == 3) begin m_hi = !m_hi; run = 0; end
              end else begin
                run = 0;
              end
              e.code[i] = m_hi ? 3'd5 : 3'd2;
            end
          end
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid[i] !== 1'b0 || out_code[i] !== 3'd2 || out_above[i] !== 1'b0 ||
          out_sum[i] !== 4'd0 || in_ready[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: got v=%b code=%0d above=%b sum=%0d rdy=%b want 0,2,0,0,0",
                 i, out_valid[i], out_code[i], out_above[i], out_sum[i], in_ready[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [2:0] av [5] = '{3'd3, 3'd6, 3'd2, 3'd1, 3'd7};
    logic [2:0] bv [5] = '{3'd2, 3'd3, 3'd2, 3'd2, 3'd7};
    int s0 [5] = '{5, 1, 4, 3, 6};
    int c0 [5] = '{5, 2, 5, 2, 5};
    int a0 [5] = '{1, 0, 1, 0, 1};
    int s1 [5] = '{5, 9, 4, 3, 14};
    int c1 [5] = '{5, 5, 5, 2, 5};
    int a1 [5] = '{1, 1, 1, 0, 1};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i >= 2) begin
        checks++;
        if (out_valid[0] !== 1'b1 || out_sum[0] !== 4'(s0[i-2]) ||
            out_code[0] !== 3'(c0[i-2]) || out_above[0] !== a0[i-2][0]) begin
          errors++;
          $display("FAIL stream_wrap[%0d]: got v=%b sum=%0d code=%0d above=%b want 1,%0d,%0d,%0d",
                   i-2, out_valid[0], out_sum[0], out_code[0], out_above[0], s0[i-2], c0[i-2], a0[i-2]);
        end
        checks++;
        if (out_valid[1] !== 1'b1 || out_sum[1] !== 4'(s1[i-2]) ||
            out_code[1] !== 3'(c1[i-2]) || out_above[1] !== a1[i-2][0]) begin
          errors++;
          $display("FAIL stream_full[%0d]: got v=%b sum=%0d code=%0d above=%b want 1,%0d,%0d,%0d",
                   i-2, out_valid[1], out_sum[1], out_code[1], out_above[1], s1[i-2], c1[i-2], a1[i-2]);
        end
      end else begin
        checks++;
        if (out_valid[0] !== 1'b0) begin
          errors++; $display("FAIL stream_latency[%0d]: got out_valid=%b want 0", i, out_valid[0]);
        end
      end
      in_valid = (i < 5);
      if (i < 5) begin a_late = av[i]; b = bv[i]; end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_persist();
    int sums  [9] = '{5, 5, 1, 5, 5, 5, 1, 1, 1};
    int codes [9] = '{2, 2, 2, 2, 2, 5, 5, 5, 2};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if (i >= 2) begin
        checks++;
        if (out_valid[2] !== 1'b1 || out_sum[2] !== 4'(sums[i-2]) ||
            out_above[2] !== (sums[i-2] >= 4) || out_code[2] !== 3'(codes[i-2])) begin
          errors++;
          $display("FAIL persist[%0d]: got v=%b sum=%0d above=%b code=%0d want 1,%0d,%b,%0d",
                   i-2, out_valid[2], out_sum[2], out_above[2], out_code[2],
                   sums[i-2], sums[i-2] >= 4, codes[i-2]);
        end
      end
      in_valid = (i < 9);
      if (i < 9) begin
        a_late = (sums[i] == 5) ? 3'd3 : 3'd6;
        b      = (sums[i] == 5) ? 3'd2 : 3'd3;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int got_sum [$];
    int got_code [$];
    int idx = 0;
    int acc_at3 = 0;
    int want_s [4] = '{5, 1, 5, 1};
    int want_c [4] = '{5, 2, 5, 2};
    do_reset();
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (idx < 4);
      a_late    = (idx % 2 == 0) ? 3'd3 : 3'd6;
      b         = (idx % 2 == 0) ? 3'd2 : 3'd3;
      #1;
      if (cyc == 2 || cyc == 3) begin
        checks++;
        if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 || out_sum[0] !== 4'd5 || out_code[0] !== 3'd5) begin
          errors++;
          $display("FAIL bp_stall[%0d]: got rdy=%b v=%b sum=%0d code=%0d want 0,1,5,5",
                   cyc, in_ready[0], out_valid[0], out_sum[0], out_code[0]);
        end
      end
      if (out_valid[0] && out_ready) begin
        got_sum.push_back(int'(out_sum[0]));
        got_code.push_back(int'(out_code[0]));
      end
      if (in_valid && in_ready[0]) idx++;
      if (cyc == 3) acc_at3 = idx;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (acc_at3 != 2) begin
      errors++; $display("FAIL bp_accepted: got %0d want 2", acc_at3);
    end
    checks++;
    if (got_sum.size() != 4) begin
      errors++; $display("FAIL bp_count: got %0d want 4", got_sum.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_sum[i] != want_s[i] || got_code[i] != want_c[i]) begin
          errors++;
          $display("FAIL bp_order[%0d]: got sum=%0d code=%0d want %0d,%0d",
                   i, got_sum[i], got_code[i], want_s[i], want_c[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    a_late = 3'd3; b = 3'd2;
    in_valid = 1'b1; tick(); tick();
    in_valid = 1'b0; tick(); tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid[2] !== 1'b0 || out_code[2] !== 3'd2 || in_ready[2] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_during: got v=%b code=%0d rdy=%b want 0,2,0", out_valid[2], out_code[2], in_ready[2]);
    end
    rst = 1'b0;
    in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    checks++;
    if (out_valid[2] !== 1'b1 || out_above[2] !== 1'b1 || out_code[2] !== 3'd2) begin
      errors++;
      $display("FAIL rstmid_fresh: got v=%b above=%b code=%0d want 1,1,2", out_valid[2], out_above[2], out_code[2]);
    end
    checks++;
    if (out_code[0] !== 3'd5) begin
      errors++; $display("FAIL rstmid_p1: got code=%0d want 5", out_code[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a_late    = 3'($urandom_range(0, 7));
      b         = 3'($urandom_range(0, 7));
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL random_drain: got %0d samples outstanding want 0", q.size());
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_stream();
    test_persist();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
